// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer.
// Fetches one word per instruction and applies the branch/jump outcome only when the instruction commits.
module pc_fetch_unit #(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned    MAX_WAIT     = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            commit,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [31:0]     Instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [31:0]     retire_cnt,
  output logic            misalign_err,
  output logic            timeout_err
);

  localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // A taken target must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  state_t            state_r, state_s;
  logic [XLEN-1:0]   pc_r, pc_s;
  logic [31:0]       instr_r, instr_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic [31:0]       retire_cnt_r, retire_cnt_s;
  logic              misalign_err_r, misalign_err_s;
  logic              timeout_err_r, timeout_err_s;
  logic              imem_req_r;
  logic              instr_valid_r;
  logic [XLEN-1:0]   pc_plus4_s;

  assign pc_plus4_s = pc_r + XLEN'(4);

  // Next-state and datapath update decisions for the fetch sequencer.
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    instr_s        = instr_r;
    wait_cnt_s     = wait_cnt_r;
    retire_cnt_s   = retire_cnt_r;
    misalign_err_s = misalign_err_r;
    timeout_err_s  = timeout_err_r;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_rvalid) begin
          instr_s    = imem_rdata;
          wait_cnt_s = {WAIT_W{1'b0}};
          state_s    = ST_EXEC;
        end else if (wait_cnt_r == WAIT_W'(MAX_WAIT)) begin
          timeout_err_s = 1'b1;
          state_s       = ST_HALT;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_EXEC: begin
        if (commit) begin
          // A misaligned taken target still retires the instruction.
          retire_cnt_s = retire_cnt_r + 32'd1;
          if (PCSrc && is_misaligned(PCTarget)) begin
            misalign_err_s = 1'b1;
            state_s        = ST_HALT;
          end else begin
            pc_s    = PCSrc ? PCTarget : pc_plus4_s;
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        state_s = ST_HALT;
      end
    endcase
  end

  // State, datapath and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      pc_r           <= RESET_VECTOR;
      instr_r        <= NOP_INSTR;
      wait_cnt_r     <= {WAIT_W{1'b0}};
      retire_cnt_r   <= 32'd0;
      misalign_err_r <= 1'b0;
      timeout_err_r  <= 1'b0;
      imem_req_r     <= 1'b0;
      instr_valid_r  <= 1'b0;
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      instr_r        <= instr_s;
      wait_cnt_r     <= wait_cnt_s;
      retire_cnt_r   <= retire_cnt_s;
      misalign_err_r <= misalign_err_s;
      timeout_err_r  <= timeout_err_s;
      imem_req_r     <= (state_s == ST_FETCH);
      instr_valid_r  <= (state_s == ST_EXEC);
    end
  end

  assign imem_req     = imem_req_r;
  assign imem_addr    = pc_r;
  assign Instr        = instr_r;
  assign instr_valid  = instr_valid_r;
  assign PC           = pc_r;
  assign PCPlus4      = pc_plus4_s;
  assign retire_cnt   = retire_cnt_r;
  assign misalign_err = misalign_err_r;
  assign timeout_err  = timeout_err_r;

endmodule
